stopwatch_unit: RTL

STOPWATCH_UNIT -- requirements
Module: stopwatch_unit

---
 rtl/stopwatch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_unit.sv
// Hundredths-resolution stopwatch: synchronised start/stop, clear and lap keys,
// 00:00.00 .. 99:59.99 counting with a lap freeze of the displayed time.
module stopwatch_unit #(
   parameter int CLK_FREQ = 50000000,
   parameter int TICK_HZ  = 100
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [6:0] stopwatch_unit_mins,
   output logic [5:0] stopwatch_unit_secs,
   output logic [6:0] stopwatch_unit_decs,
   output logic       running,
   output logic       lap_active,
   output logic       rollover
);

   localparam int TICKS = CLK_FREQ / TICK_HZ;
   localparam int PW    = (TICKS > 2) ? $clog2(TICKS) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(TICKS - 1);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

   state_t      state;
   logic [PW-1:0] presc;
   logic [6:0]  tm_mins;
   logic [5:0]  tm_secs;
   logic [6:0]  tm_decs;
   logic        lap_hold;
   logic        wrap;

   logic [2:0]  key_sync1;
   logic [2:0]  key_sync2;
   logic [2:0]  key_prev;
   logic [2:0]  key_armed;
   logic [1:0]  fill;
   logic [2:0]  events;
   logic        ev_ss;
   logic        ev_clr;
   logic        ev_lap;
   logic        tick;
   logic        at_max;

   // A key only arms after a genuine low sample, so one held through reset stays silent.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         key_sync1 <= '0;
         key_sync2 <= '0;
         key_prev  <= '0;
         key_armed <= '0;
         fill      <= '0;
      end else begin
         key_sync1 <= {lap, clear, start_stop};
         key_sync2 <= key_sync1;
         key_prev  <= key_sync2;
         fill      <= {fill[0], 1'b1};
         key_armed <= key_armed | (~key_sync2 & {3{fill[1]}});
      end
   end

   assign events = key_sync2 & ~key_prev & key_armed;
   assign ev_ss  = events[0];
   assign ev_clr = events[1];
   assign ev_lap = events[2];

   assign tick   = (state == RUNNING) && (presc == PS_MAX);
   assign at_max = (tm_decs == 7'd99) && (tm_secs == 6'd59) && (tm_mins == 7'd99);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         presc               <= '0;
         tm_mins             <= '0;
         tm_secs             <= '0;
         tm_decs             <= '0;
         lap_hold            <= 1'b0;
         wrap                <= 1'b0;
         stopwatch_unit_mins <= '0;
         stopwatch_unit_secs <= '0;
         stopwatch_unit_decs <= '0;
         running             <= 1'b0;
         lap_active          <= 1'b0;
         rollover            <= 1'b0;
      end else begin
         wrap       <= 1'b0;
         running    <= (state == RUNNING);
         lap_active <= lap_hold;
         rollover   <= wrap;
         if (!lap_hold) begin
            stopwatch_unit_mins <= tm_mins;
            stopwatch_unit_secs <= tm_secs;
            stopwatch_unit_decs <= tm_decs;
         end

         case (state)
            IDLE: begin
               if (ev_clr) begin
                  presc    <= '0;
                  tm_mins  <= '0;
                  tm_secs  <= '0;
                  tm_decs  <= '0;
                  lap_hold <= 1'b0;
               end else if (ev_ss) begin
                  state <= RUNNING;
               end
            end
            RUNNING: begin
               // A tick coinciding with start_stop is still counted before pausing.
               if (tick) begin
                  presc <= '0;
                  wrap  <= at_max;
                  if (tm_decs == 7'd99) begin
                     tm_decs <= '0;
                     if (tm_secs == 6'd59) begin
                        tm_secs <= '0;
                        tm_mins <= (tm_mins == 7'd99) ? 7'd0 : tm_mins + 7'd1;
                     end else begin
                        tm_secs <= tm_secs + 6'd1;
                     end
                  end else begin
                     tm_decs <= tm_decs + 7'd1;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
               if (ev_ss)  state    <= PAUSED;
               if (ev_lap) lap_hold <= !lap_hold;
            end
            PAUSED: begin
               if (ev_clr) begin
                  state    <= IDLE;
                  presc    <= '0;
                  tm_mins  <= '0;
                  tm_secs  <= '0;
                  tm_decs  <= '0;
                  lap_hold <= 1'b0;
               end else begin
                  if (ev_ss)             state    <= RUNNING;
                  if (ev_lap && lap_hold) lap_hold <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
